cpu_mem: RTL and testbench
==========================

Name: cpu_mem

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, between EX and the WB pipeline register.
- Passes ALU results through to WB.
- Performs loads and stores over a single-outstanding req/ack data bus, with byte-enable generation and load alignment/extension.
- Stalls the upstream pipeline while a bus access is outstanding.

Parameters:
- ACK_TIMEOUT, 0, cycles to wait for data_ack_i before aborting the access; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous assertion, active-low.
- valid_i  input  1  EX presents an instruction.
- ready_o  output  1  stage can accept; equals 1 only in IDLE.
- mem_op_i  input  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; codes 9-15 are treated as NONE.
- addr_i  input  32  effective address.
- sdata_i  input  32  store data (rt).
- we_i  input  1  register write enable from EX.
- waddr_i  input  5  destination register.
- wdata_i  input  32  ALU result.
- we_o  output  1  write enable to WB.
- waddr_o  output  5  destination register to WB.
- wdata_o  output  32  write data to WB.
- data_req_o  output  1  bus request.
- data_we_o  output  1  bus write.
- data_addr_o  output  32  bus address, bits [1:0] driven 0.
- data_be_o  output  4  byte enables, little-endian.
- data_wdata_o  output  32  bus write data.
- data_ack_i  input  1  bus completion.
- data_rdata_i  input  32  read data, valid with ack.
- exc_o  output  1  one-cycle address-error / bus-error pulse.
- badvaddr_o  output  32  faulting address, valid with exc_o.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0; timeout counter 0.
  - Any in-flight access is dropped; a late ack is ignored.
- All outputs are registered.
- IDLE, handshake valid_i & ready_o:
  - NONE op: next cycle we_o=we_i&(waddr_i!=0), waddr_o=waddr_i, wdata_o=wdata_i; state stays IDLE. Latency 1.
  - Load/store op: capture op, addr[1:0], waddr_i. Next cycle data_req_o=1, data_we_o=1 for stores, data_addr_o={addr_i[31:2],2'b00}, be and wdata set; we_o=0; state goes to WAIT.
- IDLE with valid_i=0: we_o=0; waddr_o/wdata_o hold.
- Byte enables:
  - B ops: be=4'b0001<<addr[1:0].
  - H ops: be = addr[1] ? 4'b1100 : 4'b0011.
  - W ops: be=4'b1111.
- Store data:
  - SB: byte replicated ×4.
  - SH: halfword replicated ×2.
  - SW: as-is.
- WAIT: ready_o=0; bus outputs held stable until ack.
- data_ack_i in WAIT:
  - Next cycle data_req_o=0; state goes to IDLE.
  - Load: we_o=(waddr!=0). wdata_o is the selected byte rdata[8*a+:8] or half rdata[16*a[1]+:16]; sign-extended for LB/LH, zero-extended for LBU/LHU; full word for LW.
  - Store: we_o=0.
- Store-to-load is done as two accesses; no forwarding inside this block.
- data_ack_i while in IDLE is ignored.
- Load to $0: bus access still performed; we_o=0.
- Timeout (ACK_TIMEOUT>0):
  - Counter increments each WAIT cycle without ack.
  - When counter reaches ACK_TIMEOUT: req drops; exc_o=1 for one cycle; badvaddr_o=captured full address; we_o=0; state goes to IDLE.
  - Ack in the same cycle as the timeout: ack wins.
- Total load latency: accept → req next cycle → ack cycle → we_o on the cycle after ack.

Optional Feature:
- CPU_MEM_ADDR_EXC_EN defined:
  - Misalignment (H ops with addr[0]=1; W ops with addr[1:0]!=0) issues no bus request.
  - Next cycle: exc_o=1, badvaddr_o=addr_i, we_o=0; state stays IDLE.
- CPU_MEM_ADDR_EXC_EN undefined:
  - Low bits are forced aligned: addr[0]=0 for H ops, addr[1:0]=0 for W ops.
  - exc_o is never set by misalignment; only a timeout can set it.

Test Plan:
- NONE op with we_i=1, waddr=3, wdata=0x1234 → one cycle later we_o=1, waddr_o=3, wdata_o=0x1234; data_req_o=0 throughout.
- LB at addr 0x103, ack after 3 cycles with rdata=0x80FF_0000 → be=1000, ready_o=0 for 4 cycles, then we_o=1, wdata_o=0xFFFF_FF80. Same sequence with LBU → wdata_o=0x0000_0080.
- SH at 0x202 with sdata=0xAAAA_BEEF → data_addr_o=0x200, be=1100, data_wdata_o=0xBEEF_BEEF, data_we_o=1; after ack we_o=0.
- LW with ACK_TIMEOUT=4 and no ack → req for 4 cycles, then exc_o pulse with badvaddr_o=address, ready_o returns to 1.
- LW at 0x302 → with macro: no req, exc_o=1, badvaddr_o=0x302. Without macro: data_addr_o=0x300, be=1111.
- rst asserted mid-WAIT → req drops asynchronously; a subsequent ack is ignored; next NONE op completes normally.

Source files
------------

// File: rtl/cpu_mem.sv
// cpu_mem: MIPS memory-access stage; ALU pass-through plus loads/stores over a single-outstanding req/ack bus.
// Define CPU_MEM_ADDR_EXC_EN to raise address-error exceptions on misaligned half/word accesses.
module cpu_mem #(
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] sdata_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_ack_i,
    input  logic [31:0] data_rdata_i,
    output logic        exc_o,
    output logic [31:0] badvaddr_o
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam bit TO_EN = (ACK_TIMEOUT > 0);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [1:0]       lo_q;
    logic [4:0]       wa_q;
    logic [31:0]      va_q;
    logic [CNT_W-1:0] cnt;

    logic        in_byte_c;
    logic        in_half_c;
    logic        in_word_c;
    logic        in_store_c;
    logic        in_mem_c;
    logic [1:0]  lo_c;
    logic [3:0]  be_c;
    logic [31:0] wdat_c;
    logic [7:0]  rbyte_c;
    logic [15:0] rhalf_c;
    logic [31:0] load_c;
    logic        load_q_c;

    // Decode the incoming op: access size, aligned lane, byte enables and replicated store data.
    always_comb begin
        in_byte_c  = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU) || (mem_op_i == OP_SB);
        in_half_c  = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
        in_word_c  = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
        in_store_c = (mem_op_i == OP_SB) || (mem_op_i == OP_SH) || (mem_op_i == OP_SW);
        in_mem_c   = in_byte_c || in_half_c || in_word_c;
        lo_c       = addr_i[1:0];
        be_c       = 4'b0000;
        wdat_c     = sdata_i;
        if (in_byte_c) begin
            be_c   = 4'b0001 << lo_c;
            wdat_c = {4{sdata_i[7:0]}};
        end else if (in_half_c) begin
            lo_c[0] = 1'b0;
            be_c    = lo_c[1] ? 4'b1100 : 4'b0011;
            wdat_c  = {2{sdata_i[15:0]}};
        end else if (in_word_c) begin
            lo_c = 2'b00;
            be_c = 4'b1111;
        end
    end

`ifdef CPU_MEM_ADDR_EXC_EN
    logic misalign_c;
    assign misalign_c = (in_half_c && addr_i[0]) || (in_word_c && (addr_i[1:0] != 2'b00));
`endif

    // Select and extend the loaded byte/half from the returned word.
    always_comb begin
        load_q_c = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_LH) ||
                   (op_q == OP_LHU) || (op_q == OP_LW);
        case (lo_q)
            2'd1:    rbyte_c = data_rdata_i[15:8];
            2'd2:    rbyte_c = data_rdata_i[23:16];
            2'd3:    rbyte_c = data_rdata_i[31:24];
            default: rbyte_c = data_rdata_i[7:0];
        endcase
        rhalf_c = lo_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (op_q)
            OP_LB:   load_c = {{24{rbyte_c[7]}}, rbyte_c};
            OP_LBU:  load_c = {24'd0, rbyte_c};
            OP_LH:   load_c = {{16{rhalf_c[15]}}, rhalf_c};
            OP_LHU:  load_c = {16'd0, rhalf_c};
            default: load_c = data_rdata_i;
        endcase
    end

    // Stage state machine; every output is a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            op_q         <= 4'd0;
            lo_q         <= 2'd0;
            wa_q         <= 5'd0;
            va_q         <= 32'd0;
            cnt          <= '0;
            ready_o      <= 1'b0;
            we_o         <= 1'b0;
            waddr_o      <= 5'd0;
            wdata_o      <= 32'd0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_addr_o  <= 32'd0;
            data_be_o    <= 4'd0;
            data_wdata_o <= 32'd0;
            exc_o        <= 1'b0;
            badvaddr_o   <= 32'd0;
        end else begin
            we_o  <= 1'b0;
            exc_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    ready_o <= 1'b1;
                    if (valid_i && ready_o) begin
                        if (!in_mem_c) begin
                            we_o    <= we_i && (waddr_i != 5'd0);
                            waddr_o <= waddr_i;
                            wdata_o <= wdata_i;
                        end
`ifdef CPU_MEM_ADDR_EXC_EN
                        else if (misalign_c) begin
                            exc_o      <= 1'b1;
                            badvaddr_o <= addr_i;
                        end
`endif
                        else begin
                            op_q         <= mem_op_i;
                            lo_q         <= lo_c;
                            wa_q         <= waddr_i;
                            va_q         <= addr_i;
                            cnt          <= '0;
                            data_req_o   <= 1'b1;
                            data_we_o    <= in_store_c;
                            data_addr_o  <= {addr_i[31:2], 2'b00};
                            data_be_o    <= be_c;
                            data_wdata_o <= wdat_c;
                            ready_o      <= 1'b0;
                            state        <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A completing ack takes priority over an expiring timeout.
                    if (data_ack_i) begin
                        data_req_o <= 1'b0;
                        ready_o    <= 1'b1;
                        state      <= S_IDLE;
                        if (load_q_c) begin
                            we_o    <= (wa_q != 5'd0);
                            waddr_o <= wa_q;
                            wdata_o <= load_c;
                        end
                    end else if (TO_EN && (cnt == CNT_LAST)) begin
                        data_req_o <= 1'b0;
                        ready_o    <= 1'b1;
                        state      <= S_IDLE;
                        exc_o      <= 1'b1;
                        badvaddr_o <= va_q;
                    end else if (TO_EN) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem.sv
// tb_cpu_mem: randomized bench for cpu_mem with a transaction-level reference model and per-cycle compare.
// Honours CPU_MEM_ADDR_EXC_EN the same way the design does.
module tb_cpu_mem;

    localparam int TIMEOUT = 4;
`ifdef CPU_MEM_ADDR_EXC_EN
    localparam bit ADDR_EXC = 1'b1;
`else
    localparam bit ADDR_EXC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  mem_op_i;
    logic [31:0] addr_i;
    logic [31:0] sdata_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_ack_i;
    logic [31:0] data_rdata_i;
    logic        exc_o;
    logic [31:0] badvaddr_o;

    int n_checks = 0;
    int n_errors = 0;

    cpu_mem #(.ACK_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .mem_op_i(mem_op_i), .addr_i(addr_i), .sdata_i(sdata_i),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_ack_i(data_ack_i), .data_rdata_i(data_rdata_i),
        .exc_o(exc_o), .badvaddr_o(badvaddr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Access rules expressed as arithmetic on sizes and byte lanes.
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic int lane(input logic [3:0] op, input logic [31:0] a);
        int lo;
        lo = int'(a % 32'd4);
        return lo - (lo % op_size(op));
    endfunction

    function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] a);
        logic [31:0] m;
        m = ((32'd1 << op_size(op)) - 32'd1) << lane(op, a);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_sdata(input logic [3:0] op, input logic [31:0] sd);
        case (op_size(op))
            1:       return 32'(sd[7:0]) * 32'h0101_0101;
            2:       return 32'(sd[15:0]) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
        int s;
        logic [63:0] v;
        s = op_size(op);
        v = (64'(rd) >> (8 * lane(op, a))) & ((64'd1 << (8 * s)) - 64'd1);
        if (((op == 4'd1) || (op == 4'd3)) && (v >= (64'd1 << (8 * s - 1))))
            v = v - (64'd1 << (8 * s));
        return v[31:0];
    endfunction

    // Reference model: one pending transaction plus the visible WB/exception state.
    bit          m_ready, m_busy, m_we, m_exc;
    logic [4:0]  m_waddr, t_waddr;
    logic [31:0] m_wdata, m_bad, t_addr, t_sdata;
    logic [3:0]  t_op;
    int          m_waited;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready <= 0; m_busy <= 0; m_we <= 0; m_exc <= 0;
            m_waddr <= '0; m_wdata <= '0; m_bad <= '0;
            t_op <= '0; t_addr <= '0; t_sdata <= '0; t_waddr <= '0; m_waited <= 0;
        end else begin
            m_we  <= 0;
            m_exc <= 0;
            if (!m_busy) begin
                m_ready <= 1;
                if (valid_i && m_ready) begin
                    if (op_size(mem_op_i) == 0) begin
                        m_we    <= we_i && (waddr_i != 0);
                        m_waddr <= waddr_i;
                        m_wdata <= wdata_i;
                    end else if (ADDR_EXC && ((addr_i % 32'(op_size(mem_op_i))) != 0)) begin
                        m_exc <= 1;
                        m_bad <= addr_i;
                    end else begin
                        m_busy   <= 1;
                        m_ready  <= 0;
                        t_op     <= mem_op_i;
                        t_addr   <= addr_i;
                        t_sdata  <= sdata_i;
                        t_waddr  <= waddr_i;
                        m_waited <= 0;
                    end
                end
            end else begin
                m_ready <= 0;
                if (data_ack_i) begin
                    m_busy  <= 0;
                    m_ready <= 1;
                    if (!op_store(t_op)) begin
                        m_we    <= (t_waddr != 0);
                        m_waddr <= t_waddr;
                        m_wdata <= load_val(t_op, t_addr, data_rdata_i);
                    end
                end else if (m_waited + 1 == TIMEOUT) begin
                    m_busy  <= 0;
                    m_ready <= 1;
                    m_exc   <= 1;
                    m_bad   <= t_addr;
                end else begin
                    m_waited <= m_waited + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("ready", 32'(ready_o), 32'(m_ready));
            chk("req", 32'(data_req_o), 32'(m_busy));
            chk("we", 32'(we_o), 32'(m_we));
            chk("waddr", 32'(waddr_o), 32'(m_waddr));
            chk("wdata", wdata_o, m_wdata);
            chk("exc", 32'(exc_o), 32'(m_exc));
            if (m_exc) chk("badvaddr", badvaddr_o, m_bad);
            if (m_busy) begin
                chk("bus_we", 32'(data_we_o), 32'(op_store(t_op)));
                chk("bus_addr", data_addr_o, t_addr & 32'hFFFF_FFFC);
                chk("bus_be", 32'(data_be_o), 32'(exp_be(t_op, t_addr)));
                if (op_store(t_op)) chk("bus_wdata", data_wdata_o, exp_sdata(t_op, t_sdata));
            end
        end
    end

    // Bus responder: acks after a chosen number of request cycles, or manual control.
    bit          resp_on = 1, resp_rand = 0, spur_en = 0, resp_active = 0;
    bit          resp_ack = 0, man_ack = 0;
    int          resp_wait = 0, resp_target = 0, fixed_target = 0;
    logic [31:0] resp_rdata = '0, fixed_rdata = '0;

    assign data_ack_i   = resp_on ? resp_ack : man_ack;
    assign data_rdata_i = resp_rdata;

    always @(negedge clk) begin
        resp_ack = 0;
        if (rst && data_req_o) begin
            if (!resp_active) begin
                resp_active = 1;
                resp_wait   = 0;
                resp_target = resp_rand ? int'($urandom_range(0, 5)) : fixed_target;
            end
            if (resp_wait >= resp_target) begin
                resp_ack    = 1;
                resp_rdata  = resp_rand ? $urandom : fixed_rdata;
                resp_active = 0;
            end else begin
                resp_wait++;
            end
        end else begin
            resp_active = 0;
            if (spur_en) begin
                resp_ack   = ($urandom_range(0, 7) == 0);
                resp_rdata = $urandom;
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        int n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) chk("ready_wait", 32'(ready_o), 32'd1);
        valid_i = 1; mem_op_i = op; addr_i = a; sdata_i = sd;
        we_i = we; waddr_i = wa; wdata_i = wd;
        @(negedge clk);
        valid_i = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) chk("ready_wait", 32'(ready_o), 32'd1);
    endtask

    initial begin
        int n;
        rst = 0; valid_i = 0; mem_op_i = 0; addr_i = 0; sdata_i = 0;
        we_i = 0; waddr_i = 0; wdata_i = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_req", 32'(data_req_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_exc", 32'(exc_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        rst = 1;

        send(4'd0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h1234);
        chk("lit_none_we", 32'(we_o), 32'd1);
        chk("lit_none_waddr", 32'(waddr_o), 32'd3);
        chk("lit_none_wdata", wdata_o, 32'h1234);
        chk("lit_none_req", 32'(data_req_o), 32'd0);

        fixed_target = 3; fixed_rdata = 32'h80FF_0000;
        for (int k = 0; k < 2; k++) begin
            send(k == 0 ? 4'd1 : 4'd2, 32'h103, 32'h0, 1'b1, 5'd5, 32'h0);
            chk("lit_lb_be", 32'(data_be_o), 32'b1000);
            n = 0;
            while (!ready_o && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk("lit_lb_stall", 32'(n), 32'd4);
            chk("lit_lb_we", 32'(we_o), 32'd1);
            chk("lit_lb_wdata", wdata_o, k == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
        end

        fixed_target = 0;
        send(4'd7, 32'h202, 32'hAAAA_BEEF, 1'b1, 5'd6, 32'h0);
        chk("lit_sh_addr", data_addr_o, 32'h200);
        chk("lit_sh_be", 32'(data_be_o), 32'b1100);
        chk("lit_sh_wdata", data_wdata_o, 32'hBEEF_BEEF);
        chk("lit_sh_bus_we", 32'(data_we_o), 32'd1);
        wait_ready();
        chk("lit_sh_we", 32'(we_o), 32'd0);

        resp_on = 0; man_ack = 0;
        send(4'd5, 32'h400, 32'h0, 1'b1, 5'd7, 32'h0);
        n = 0;
        while (data_req_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("lit_to_req_cycles", 32'(n), 32'd4);
        chk("lit_to_exc", 32'(exc_o), 32'd1);
        chk("lit_to_bad", badvaddr_o, 32'h400);
        chk("lit_to_ready", 32'(ready_o), 32'd1);
        resp_on = 1;

        send(4'd5, 32'h302, 32'h0, 1'b1, 5'd8, 32'h0);
`ifdef CPU_MEM_ADDR_EXC_EN
        chk("lit_mis_req", 32'(data_req_o), 32'd0);
        chk("lit_mis_exc", 32'(exc_o), 32'd1);
        chk("lit_mis_bad", badvaddr_o, 32'h302);
`else
        chk("lit_mis_addr", data_addr_o, 32'h300);
        chk("lit_mis_be", 32'(data_be_o), 32'b1111);
`endif
        wait_ready();

        resp_on = 0; man_ack = 0;
        send(4'd5, 32'h500, 32'h0, 1'b1, 5'd9, 32'h0);
        #2 rst = 0;
        #1 chk("lit_arst_req", 32'(data_req_o), 32'd0);
        man_ack = 1;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        man_ack = 0;
        chk("lit_arst_we", 32'(we_o), 32'd0);
        chk("lit_arst_req2", 32'(data_req_o), 32'd0);
        resp_on = 1;
        send(4'd0, 32'h0, 32'h0, 1'b1, 5'd4, 32'hCAFE);
        chk("lit_arst_none_we", 32'(we_o), 32'd1);
        chk("lit_arst_none_wdata", wdata_o, 32'hCAFE);

        resp_rand = 1; spur_en = 1;
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) begin
                mem_op_i = 4'($urandom); addr_i = $urandom; we_i = 1'($urandom);
                @(negedge clk);
            end
            send(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
        end
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
